// File: rtl/alu16_flagged.sv
// Registered execute-stage ALU: adder, incrementer and comparator run in parallel,
// a result mux selects by ALUControl, and a 5-bit {E,N,Z,C,V} flag register tracks status.
module alu16_flagged #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] RESULT,
  output logic [4:0]       Flags
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_INC  = 3'b001,
    OP_CMP  = 3'b010,
    OP_LS   = 3'b011,
    OP_MOV  = 3'b100,
    OP_B    = 3'b101,
    OP_RES6 = 3'b110,
    OP_RES7 = 3'b111
  } alu_op_e;

  localparam int FLAG_E = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       flags_q,  flags_d;

  // Parallel arithmetic units, each one bit wider so the MSB is the carry out.
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] inc_sum;
  logic [WIDTH:0] sub_sum;
  logic           add_ovf;
  logic           inc_ovf;
  logic           sub_ovf;
  logic           opnd_eq;

  assign add_sum = {1'b0, A} + {1'b0, B};
  assign inc_sum = {1'b0, A} + (WIDTH+1)'(1);
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);

  assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
  assign inc_ovf = !A[WIDTH-1] && inc_sum[WIDTH-1];
  assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
  assign opnd_eq = (A == B);

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    if (en) begin
      unique case (alu_op_e'(ALUControl))
        OP_ADD: begin
          result_d       = add_sum[WIDTH-1:0];
          flags_d[FLAG_N] = add_sum[WIDTH-1];
          flags_d[FLAG_Z] = (add_sum[WIDTH-1:0] == '0);
          flags_d[FLAG_C] = add_sum[WIDTH];
          flags_d[FLAG_V] = add_ovf;
        end
        OP_INC: begin
          result_d       = inc_sum[WIDTH-1:0];
          flags_d[FLAG_N] = inc_sum[WIDTH-1];
          flags_d[FLAG_Z] = (inc_sum[WIDTH-1:0] == '0);
          flags_d[FLAG_C] = inc_sum[WIDTH];
          flags_d[FLAG_V] = inc_ovf;
        end
        OP_CMP: begin
          // Carry set means no borrow, i.e. A >= B unsigned.
          result_d       = sub_sum[WIDTH-1:0];
          flags_d[FLAG_E] = opnd_eq;
          flags_d[FLAG_N] = sub_sum[WIDTH-1];
          flags_d[FLAG_Z] = (sub_sum[WIDTH-1:0] == '0);
          flags_d[FLAG_C] = sub_sum[WIDTH];
          flags_d[FLAG_V] = sub_ovf;
        end
        OP_LS:          result_d = A;
        OP_MOV, OP_B:   result_d = B;
        OP_RES6, OP_RES7: result_d = '0;
        default:        result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign RESULT = result_q;
  assign Flags  = flags_q;

endmodule

// File: tb/tb_alu16_flagged.sv
// Scoreboard bench for alu16_flagged: a driver pushes model predictions into a queue,
// an independent monitor pops one entry per clock and compares RESULT and Flags.
module tb_alu16_flagged;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  ALUControl;
  logic [15:0] RESULT;
  logic [4:0]  Flags;

  alu16_flagged #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .RESULT     (RESULT),
    .Flags      (Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [4:0]  flg;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;

  // Reference architectural state.
  logic [15:0] m_res;
  logic        m_e, m_n, m_z, m_c, m_v;

  task automatic model(input logic r, input logic e, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] op);
    int u, s;
    if (r) begin
      m_res = 16'h0;
      {m_e, m_n, m_z, m_c, m_v} = 5'b0;
      return;
    end
    if (!e) return;
    case (op)
      3'd0, 3'd1: begin
        int bb;
        int bs;
        bb = (op == 3'd0) ? int'(b) : 1;
        bs = (op == 3'd0) ? int'($signed(b)) : 1;
        u = int'(a) + bb;
        s = int'($signed(a)) + bs;
        m_res = 16'(u % 65536);
        m_c = (u > 65535);
        m_v = (s > 32767) || (s < -32768);
        m_n = (m_res >= 16'h8000);
        m_z = (m_res == 16'h0);
      end
      3'd2: begin
        u = int'(a) - int'(b);
        s = int'($signed(a)) - int'($signed(b));
        m_res = 16'((u < 0) ? u + 65536 : u);
        m_c = (a >= b);
        m_v = (s > 32767) || (s < -32768);
        m_n = (m_res >= 16'h8000);
        m_z = (m_res == 16'h0);
        m_e = (a == b);
      end
      3'd3:       m_res = a;
      3'd4, 3'd5: m_res = b;
      default:    m_res = 16'h0;
    endcase
  endtask

  task automatic step(input string name, input logic r, input logic e,
                      input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; A = a; B = b; ALUControl = op;
    model(r, e, a, b, op);
    x.name = name;
    x.res  = m_res;
    x.flg  = {m_e, m_n, m_z, m_c, m_v};
    exp_q.push_back(x);
  endtask

  // Monitor: the DUT presents a new registered output after every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      n_txn++;
      n_checks++;
      if (RESULT === x.res) n_pass++;
      else $display("FAIL %s RESULT got %h expected %h", x.name, RESULT, x.res);
      n_checks++;
      if (Flags === x.flg) n_pass++;
      else $display("FAIL %s Flags got %b expected %b", x.name, Flags, x.flg);
      $display("txn %0d %s RESULT=%h Flags=%b", n_txn, x.name, RESULT, Flags);
    end
  end

  function automatic logic [15:0] rand_opnd();
    case ($urandom_range(5, 0))
      0:       return 16'hFFFF;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; A = 16'h1234; B = 16'h0001; ALUControl = 3'b000;

    step("reset0", 1, 1, 16'h1234, 16'h0001, 3'b000);
    step("reset1", 1, 1, 16'h1234, 16'h0001, 3'b000);
    step("post_reset_add", 0, 1, 16'h1234, 16'h0001, 3'b000);
    step("add_carry_zero", 0, 1, 16'hFFFF, 16'h0001, 3'b000);
    step("add_overflow", 0, 1, 16'h7FFF, 16'h0001, 3'b000);
    step("inc_overflow", 0, 1, 16'h7FFF, 16'h0000, 3'b001);
    step("inc_wrap", 0, 1, 16'hFFFF, 16'h0000, 3'b001);
    step("cmp_equal", 0, 1, 16'h00A5, 16'h00A5, 3'b010);
    step("mov_hold", 0, 1, 16'h0000, 16'hBEEF, 3'b100);
    step("ls_hold", 0, 1, 16'h0040, 16'h0000, 3'b011);
    step("reserved7", 0, 1, 16'h1111, 16'h2222, 3'b111);
    step("cmp_less", 0, 1, 16'h0003, 16'h0005, 3'b010);
    step("branch", 0, 1, 16'h0000, 16'h4321, 3'b101);
    step("reserved6", 0, 1, 16'h5555, 16'h6666, 3'b110);
    for (int i = 0; i < 3; i++) step("en_low_hold", 0, 0, 16'h0001, 16'h0001, 3'b000);
    step("rst_over_cmp", 1, 1, 16'h0009, 16'h0009, 3'b010);

    for (int i = 0; i < 400; i++) begin
      logic r, e;
      r = ($urandom_range(39, 0) == 0);
      e = ($urandom_range(7, 0) != 0);
      step("random", r, e, rand_opnd(), rand_opnd(), 3'($urandom_range(7, 0)));
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain pending got %0d expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu16_flagged.md
Name: alu16_flagged

Overview:
- Registered 16-bit datapath ALU for the processor execute stage.
- It contains an adder, an incrementer, an equality/magnitude comparator, result selection and a 5-bit status flag register.
- Result and flags are registered on the clock edge and consumed by writeback and branch logic.

Parameters:
- WIDTH, 16, operand and result width in bits. Flag positions are fixed independent of WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  operation enable. When low, RESULT and Flags hold their values.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALUControl  input  3  operation select.
- RESULT  output  WIDTH  registered operation result.
- Flags  output  5  registered status flags {E,N,Z,C,V}: bit4=E, bit3=N, bit2=Z, bit1=C, bit0=V.

Behaviour:
- Reset: on a rising clk edge with rst=1, RESULT=0 and Flags=5'b00000. Reset has priority over en and over any in-flight operation.
- Latency: 1 cycle. Inputs sampled at edge k with en=1 appear on RESULT and Flags after edge k. There is no stall or handshake beyond en.
- Arithmetic is computed at WIDTH+1 bits; the carry is the MSB, and RESULT wraps modulo 2^WIDTH.

Operations (ALUControl):
- 000 add: RESULT=A+B.
  - C = carry out.
  - V = (A[15]==B[15]) && (R[15]!=A[15]).
  - N = R[15]; Z = (R==0).
  - E holds its previous value.
- 001 inc: RESULT=A+1.
  - C=1 only when A=16'hFFFF.
  - V=1 only when A=16'h7FFF.
  - N and Z from the result; E holds.
- 010 cmp: RESULT=A-B, computed as A+~B+1.
  - C = carry out (1 means no borrow, i.e. A>=B unsigned).
  - V = (A[15]!=B[15]) && (R[15]!=A[15]).
  - N = R[15]; Z = (R==0).
  - E = (A==B).
- 011 load/store: RESULT=A (address pass-through). All flags hold.
- 100 mov: RESULT=B. All flags hold.
- 101 b: RESULT=B (branch target pass-through). All flags hold.
- 110, 111 reserved: RESULT=0. All flags hold.

Flag rules:
- Flags that are not updated keep their registered value. Only add, inc and cmp modify flags.
- The E and Z flags are both set on cmp of equal operands; E is not touched by add or inc.
- en=0 with any ALUControl: no state change.
- Combinational paths: the adder, incrementer and comparator evaluate in parallel; the mux selects by ALUControl. No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst for 2 cycles with A=16'h1234, B=1, ALUControl=000, en=1 -> RESULT=0, Flags=00000. Release rst -> next edge RESULT=16'h1235, Flags=00000.
- Add carry/zero: A=16'hFFFF, B=16'h0001, add -> RESULT=0000, Flags=00110 (Z=1, C=1). Then A=16'h7FFF, B=1, add -> RESULT=8000, Flags=01001 (N=1, V=1).
- Inc: A=16'h7FFF, inc -> RESULT=8000, N=1, V=1, C=0. Then A=16'hFFFF, inc -> RESULT=0000, Z=1, C=1, V=0.
- Cmp: A=B=16'h00A5, cmp -> RESULT=0, Flags=10110. Then A=3, B=5 -> RESULT=FFFE, Flags=01000 (E=0, N=1, C=0).
- Flag hold: after the equal cmp (Flags=10110), issue mov with B=16'hBEEF -> RESULT=BEEF, Flags=10110. Then ls with A=16'h0040 -> RESULT=0040, Flags unchanged. Then reserved op 111 -> RESULT=0, Flags unchanged.
- Enable/reset mid-stream: en=0 with add A=1, B=1 -> RESULT and Flags hold for 3 cycles. Then rst=1 together with en=1 and a cmp -> RESULT=0, Flags=00000.
